// File: rtl/cdb_arbiter_if.sv
// Requester-side handshake/payload and registered CDB broadcast for cdb_arbiter.
interface cdb_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int PRD_WIDTH  = 6,
  parameter int ROB_WIDTH  = 5,
  parameter int DATA_WIDTH = 32
);
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*PRD_WIDTH-1:0]  req_prd;
  logic [NUM_REQ*ROB_WIDTH-1:0]  req_rob;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;

  logic                          cdb_valid;
  logic [PRD_WIDTH-1:0]          cdb_prd;
  logic [ROB_WIDTH-1:0]          cdb_rob;
  logic [DATA_WIDTH-1:0]         cdb_data;
  logic [SRC_W-1:0]              cdb_src;

  modport slave (
    input  req_valid, req_prd, req_rob, req_data,
    output req_ready, cdb_valid, cdb_prd, cdb_rob, cdb_data, cdb_src
  );

  modport master (
    output req_valid, req_prd, req_rob, req_data,
    input  req_ready, cdb_valid, cdb_prd, cdb_rob, cdb_data, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter with registered broadcast and saturating per-requester grant counters.
module cdb_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int PRD_WIDTH  = 6,
  parameter int ROB_WIDTH  = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  cdb_arbiter_if.slave                 bus,
  input  logic                         flush,
  input  logic                         cnt_clr,
  output logic [NUM_REQ*CNT_WIDTH-1:0] grant_cnt
);
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [SRC_W-1:0]      r_ptr;
  logic                  r_valid;
  logic [PRD_WIDTH-1:0]  r_prd;
  logic [ROB_WIDTH-1:0]  r_rob;
  logic [DATA_WIDTH-1:0] r_data;
  logic [SRC_W-1:0]      r_src;

  logic [NUM_REQ-1:0]    w_ready;
  logic                  w_gnt_any;
  logic [SRC_W-1:0]      w_gnt_idx;
  logic [SRC_W-1:0]      w_ptr_nxt;

  // Scan from the pointer with modular wrap; flush suppresses every grant.
  always_comb begin
    logic [SRC_W-1:0] cand;
    w_ready   = '0;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    cand      = '0;
    if (!flush) begin
      for (int unsigned k = 0; k < unsigned'(NUM_REQ); k++) begin
        cand = SRC_W'((32'(r_ptr) + k) % unsigned'(NUM_REQ));
        if (!w_gnt_any && bus.req_valid[cand]) begin
          w_gnt_any     = 1'b1;
          w_gnt_idx     = cand;
          w_ready[cand] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_ptr_nxt = '0;
    if (w_gnt_idx != SRC_W'(NUM_REQ - 1)) begin
      w_ptr_nxt = w_gnt_idx + SRC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_prd   <= '0;
      r_rob   <= '0;
      r_data  <= '0;
      r_src   <= '0;
    end else begin
      r_valid <= w_gnt_any;
      if (w_gnt_any) begin
        r_ptr  <= w_ptr_nxt;
        r_prd  <= bus.req_prd[w_gnt_idx*PRD_WIDTH +: PRD_WIDTH];
        r_rob  <= bus.req_rob[w_gnt_idx*ROB_WIDTH +: ROB_WIDTH];
        r_data <= bus.req_data[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        r_src  <= w_gnt_idx;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (cnt_clr) begin
        r_cnt <= '0;
      end else if (w_ready[g] && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end

    assign grant_cnt[g*CNT_WIDTH +: CNT_WIDTH] = r_cnt;
  end

  assign bus.req_ready = w_ready;
  assign bus.cdb_valid = r_valid;
  assign bus.cdb_prd   = r_prd;
  assign bus.cdb_rob   = r_rob;
  assign bus.cdb_data  = r_data;
  assign bus.cdb_src   = r_src;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, round-robin, sparse, flush, single requester, saturation.
module tb_cdb_arbiter;
  localparam int NR = 4;
  localparam int PW = 6;
  localparam int RW = 5;
  localparam int DW = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic cnt_clr = 1'b0;
  logic [NR*CW-1:0] grant_cnt;

  int errors = 0;
  int checks = 0;

  logic [PW-1:0] prd_tab [NR] = '{6'h05, 6'h1A, 6'h2F, 6'h3C};
  logic [RW-1:0] rob_tab [NR] = '{5'h03, 5'h0C, 5'h15, 5'h1E};
  logic [DW-1:0] dat_tab [NR] = '{32'hDEAD0000, 32'h1111BEEF, 32'h2222CAFE, 32'h3333F00D};

  cdb_arbiter_if #(.NUM_REQ(NR), .PRD_WIDTH(PW), .ROB_WIDTH(RW), .DATA_WIDTH(DW)) bus ();

  cdb_arbiter #(
    .NUM_REQ(NR), .PRD_WIDTH(PW), .ROB_WIDTH(RW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush),
    .cnt_clr(cnt_clr), .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] cnt(input int i);
    return grant_cnt[i*CW +: CW];
  endfunction

  function automatic logic [PW+RW+DW+2:0] exp_bc(input int i);
    return {1'b1, 2'(i), prd_tab[i], rob_tab[i], dat_tab[i]};
  endfunction

  function automatic logic [PW+RW+DW+2:0] act_bc();
    return {bus.cdb_valid, bus.cdb_src, bus.cdb_prd, bus.cdb_rob, bus.cdb_data};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; bus.req_valid = '0; flush = 1'b0; cnt_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (act_bc() !== '0) begin
      errors++; $display("FAIL reset_bcast: got %h exp 0", act_bc());
    end
    checks++;
    if (grant_cnt !== '0) begin
      errors++; $display("FAIL reset_cnt: got %h exp 0", grant_cnt);
    end
    rst_n = 1'b1; bus.req_valid = 4'b1111; #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++; $display("FAIL reset_first_ready: got %b exp 0001", bus.req_ready);
    end
    @(negedge clk);
    checks++;
    if (act_bc() !== exp_bc(0)) begin
      errors++; $display("FAIL reset_pre_bcast: got %h exp %h", act_bc(), exp_bc(0));
    end
    rst_n = 1'b0; #1;
    checks++;
    if (act_bc() !== '0) begin
      errors++; $display("FAIL reset_async_bcast: got %h exp 0", act_bc());
    end
    checks++;
    if (grant_cnt !== '0) begin
      errors++; $display("FAIL reset_async_cnt: got %h exp 0", grant_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1; #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++; $display("FAIL reset_release_ready: got %b exp 0001", bus.req_ready);
    end
    bus.req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++;
      if (bus.req_ready !== 4'(1 << (c % 4))) begin
        errors++; $display("FAIL rr_ready c=%0d: got %b exp %b", c, bus.req_ready, 4'(1 << (c % 4)));
      end
      @(negedge clk);
      checks++;
      if (act_bc() !== exp_bc(c % 4)) begin
        errors++; $display("FAIL rr_bcast c=%0d: got %h exp %h", c, act_bc(), exp_bc(c % 4));
      end
    end
    bus.req_valid = '0;
    for (int i = 0; i < NR; i++) begin
      checks++;
      if (cnt(i) !== 16'd2) begin
        errors++; $display("FAIL rr_cnt%0d: got %0d exp 2", i, cnt(i));
      end
    end
  endtask

  task automatic test_sparse();
    do_reset();
    bus.req_valid = 4'b1010; #1;
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      errors++; $display("FAIL sparse_ready1: got %b exp 0010", bus.req_ready);
    end
    @(negedge clk);
    checks++;
    if (act_bc() !== exp_bc(1)) begin
      errors++; $display("FAIL sparse_bcast1: got %h exp %h", act_bc(), exp_bc(1));
    end
    #1;
    checks++;
    if (bus.req_ready !== 4'b1000) begin
      errors++; $display("FAIL sparse_ready3: got %b exp 1000", bus.req_ready);
    end
    @(negedge clk);
    checks++;
    if (act_bc() !== exp_bc(3)) begin
      errors++; $display("FAIL sparse_bcast3: got %h exp %h", act_bc(), exp_bc(3));
    end
    bus.req_valid = 4'b0000; #1;
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++; $display("FAIL sparse_idle_ready: got %b exp 0000", bus.req_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.cdb_valid !== 1'b0) begin
      errors++; $display("FAIL sparse_idle_valid: got %b exp 0", bus.cdb_valid);
    end
    bus.req_valid = 4'b1111; #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++; $display("FAIL sparse_ptr_hold: got %b exp 0001", bus.req_ready);
    end
    bus.req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_flush();
    do_reset();
    bus.req_valid = 4'b0001;
    @(negedge clk);
    flush = 1'b1; bus.req_valid = 4'b0100; #1;
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++; $display("FAIL flush_ready: got %b exp 0000", bus.req_ready);
    end
    checks++;
    if (act_bc() !== exp_bc(0)) begin
      errors++; $display("FAIL flush_visible_bcast: got %h exp %h", act_bc(), exp_bc(0));
    end
    @(negedge clk);
    checks++;
    if (bus.cdb_valid !== 1'b0) begin
      errors++; $display("FAIL flush_next_valid: got %b exp 0", bus.cdb_valid);
    end
    checks++;
    if (cnt(2) !== 16'd0) begin
      errors++; $display("FAIL flush_cnt2: got %0d exp 0", cnt(2));
    end
    flush = 1'b0; bus.req_valid = 4'b1111; #1;
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      errors++; $display("FAIL flush_ptr_hold: got %b exp 0010", bus.req_ready);
    end
    bus.req_valid = 4'b0100; #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      errors++; $display("FAIL flush_release_ready: got %b exp 0100", bus.req_ready);
    end
    @(negedge clk);
    checks++;
    if (act_bc() !== exp_bc(2)) begin
      errors++; $display("FAIL flush_release_bcast: got %h exp %h", act_bc(), exp_bc(2));
    end
    bus.req_valid = '0;
  endtask

  task automatic test_single();
    do_reset();
    bus.req_valid = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (bus.req_ready !== 4'b0001) begin
        errors++; $display("FAIL single_ready c=%0d: got %b exp 0001", c, bus.req_ready);
      end
      @(negedge clk);
      checks++;
      if (act_bc() !== exp_bc(0)) begin
        errors++; $display("FAIL single_bcast c=%0d: got %h exp %h", c, act_bc(), exp_bc(0));
      end
    end
    bus.req_valid = '0;
    checks++;
    if (cnt(0) !== 16'd5) begin
      errors++; $display("FAIL single_cnt0: got %0d exp 5", cnt(0));
    end
    @(negedge clk);
    checks++;
    if (bus.cdb_valid !== 1'b0) begin
      errors++; $display("FAIL single_end_valid: got %b exp 0", bus.cdb_valid);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    bus.req_valid = 4'b1000;
    repeat (65535) @(negedge clk);
    checks++;
    if (cnt(3) !== 16'hFFFF) begin
      errors++; $display("FAIL sat_reach: got %h exp FFFF", cnt(3));
    end
    repeat (3) @(negedge clk);
    checks++;
    if (cnt(3) !== 16'hFFFF) begin
      errors++; $display("FAIL sat_hold: got %h exp FFFF", cnt(3));
    end
    checks++;
    if (grant_cnt[3*CW-1:0] !== '0) begin
      errors++; $display("FAIL sat_others: got %h exp 0", grant_cnt[3*CW-1:0]);
    end
    cnt_clr = 1'b1; #1;
    checks++;
    if (bus.req_ready !== 4'b1000) begin
      errors++; $display("FAIL clr_ready: got %b exp 1000", bus.req_ready);
    end
    @(negedge clk);
    checks++;
    if (cnt(3) !== 16'd0) begin
      errors++; $display("FAIL clr_priority: got %h exp 0", cnt(3));
    end
    checks++;
    if (act_bc() !== exp_bc(3)) begin
      errors++; $display("FAIL clr_bcast: got %h exp %h", act_bc(), exp_bc(3));
    end
    cnt_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (cnt(3) !== 16'd1) begin
      errors++; $display("FAIL clr_resume: got %h exp 1", cnt(3));
    end
    bus.req_valid = '0;
  endtask

  initial begin
    bus.req_valid = '0;
    for (int i = 0; i < NR; i++) begin
      bus.req_prd[i*PW +: PW]  = prd_tab[i];
      bus.req_rob[i*RW +: RW]  = rob_tab[i];
      bus.req_data[i*DW +: DW] = dat_tab[i];
    end
    test_reset();
    test_round_robin();
    test_sparse();
    test_flush();
    test_single();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
